tac_event_packetizer: RTL and testbench

- Sits directly downstream of the NIM TAC time-interval FIFO, in the Ethernet clock domain.
- Accepts 64-bit TAC result words on a valid-only interface and gives back a ready/enable signal.
- Buffers the words, then frames them into AXI-Stream packets for the UDP transmit path: one header word plus up to MAX_WORDS payload words.
- A packet launches when MAX_WORDS words are buffered, when a timeout expires, or when software requests a flush.

---
 rtl/tac_event_packetizer_if.sv | 20 ++
 rtl/tac_event_packetizer.sv | 191 +++++++++++++++++++
 tb/tb_tac_event_packetizer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tac_event_packetizer_if.sv
// rtl/tac_event_packetizer_if.sv - TAC word input and AXI-Stream packet output bundle
interface tac_event_packetizer_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    input  in_data, in_valid, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output in_data, in_valid, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/tac_event_packetizer.sv
// rtl/tac_event_packetizer.sv - buffers TAC words and frames them into header+payload packets
// Optional trailer word (timestamp + drop count) enabled by `define PKT_TRAILER_EN.
module tac_event_packetizer #(
  parameter int          DEPTH     = 512,
  parameter int          MAX_WORDS = 64,
  parameter int          TIMEOUT   = 125000,
  parameter logic [15:0] MAGIC     = 16'hA5C3
) (
  input  logic                          clk,
  input  logic                          reset,
  tac_event_packetizer_if.master        bus,
  input  logic                          flush_req,
  output logic [31:0]                   pkt_count,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
  localparam logic [FW-1:0] MAX_F   = FW'(MAX_WORDS);
  localparam logic [15:0]   MAX_N   = 16'(MAX_WORDS);
  localparam logic [31:0]   TMO_M1  = 32'(TIMEOUT - 1);

`ifdef PKT_TRAILER_EN
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif

  state_t state;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] fill;
  logic          wr_en;
  logic          rd_en;
  logic [63:0]   head;

  logic [63:0]   hdr_r;
  logic [15:0]   rem_r;
  logic [15:0]   seq;
  logic [31:0]   timer;
  logic          valid_r;
  logic          last_r;
  logic          launch;
  logic [15:0]   launch_n;

`ifdef PKT_TRAILER_EN
  logic [47:0]   ts;
  logic [63:0]   trl_r;
`endif

  assign bus.in_ready = (fill < DEPTH_F);
  assign wr_en        = bus.in_valid && bus.in_ready;
  assign rd_en        = (state == PAYLOAD) && bus.m_axis_tready;
  assign head         = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (bus.in_valid && !bus.in_ready && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

`ifdef PKT_TRAILER_EN
  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + 48'd1;
  end
`endif

  // Timeout term is gated by fill so TIMEOUT==1 never launches an empty packet.
  assign launch   = (fill >= MAX_F) ||
                    ((fill != '0) && (timer == TMO_M1)) ||
                    (flush_req && (fill != '0));
  assign launch_n = (fill >= MAX_F) ? MAX_N : 16'(fill);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      hdr_r     <= '0;
      rem_r     <= '0;
      seq       <= '0;
      timer     <= '0;
      pkt_count <= '0;
`ifdef PKT_TRAILER_EN
      trl_r     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= HEADER;
            valid_r <= 1'b1;
            last_r  <= 1'b0;
            hdr_r   <= {MAGIC, seq, launch_n, 16'h0000};
            rem_r   <= launch_n;
            timer   <= '0;
`ifdef PKT_TRAILER_EN
            trl_r   <= {drop_count, ts};
`endif
          end else if (fill != '0) begin
            timer <= timer + 32'd1;
          end else begin
            timer <= '0;
          end
        end
        HEADER: begin
          if (bus.m_axis_tready) begin
            state <= PAYLOAD;
`ifdef PKT_TRAILER_EN
            last_r <= 1'b0;
`else
            last_r <= (rem_r == 16'd1);
`endif
          end
        end
        PAYLOAD: begin
          if (bus.m_axis_tready) begin
            rem_r <= rem_r - 16'd1;
            if (rem_r == 16'd1) begin
`ifdef PKT_TRAILER_EN
              state  <= TRAILER;
              last_r <= 1'b1;
`else
              state     <= IDLE;
              valid_r   <= 1'b0;
              last_r    <= 1'b0;
              seq       <= seq + 16'd1;
              pkt_count <= pkt_count + 32'd1;
`endif
            end else begin
`ifdef PKT_TRAILER_EN
              last_r <= 1'b0;
`else
              last_r <= (rem_r == 16'd2);
`endif
            end
          end
        end
`ifdef PKT_TRAILER_EN
        TRAILER: begin
          if (bus.m_axis_tready) begin
            state     <= IDLE;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            seq       <= seq + 16'd1;
            pkt_count <= pkt_count + 32'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.m_axis_tdata = '0;
    case (state)
      HEADER:  bus.m_axis_tdata = hdr_r;
      PAYLOAD: bus.m_axis_tdata = head;
`ifdef PKT_TRAILER_EN
      TRAILER: bus.m_axis_tdata = trl_r;
`endif
      default: bus.m_axis_tdata = '0;
    endcase
  end

  assign bus.m_axis_tvalid = valid_r;
  assign bus.m_axis_tlast  = last_r;

endmodule

// File: tb/tb_tac_event_packetizer.sv
// tb/tb_tac_event_packetizer.sv - scoreboard bench for tac_event_packetizer
module tb_tac_event_packetizer;
  localparam int DEPTH     = 512;
  localparam int MAX_WORDS = 64;
  localparam int TIMEOUT   = 200;

  logic        clk;
  logic        reset;
  logic        flush_req;
  logic [31:0] pkt_count;
  logic [15:0] drop_count;

  tac_event_packetizer_if bus ();

  tac_event_packetizer #(
    .DEPTH(DEPTH), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT), .MAGIC(16'hA5C3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .flush_req(flush_req),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [64:0] exp_q [$];
  logic [15:0] exp_seq = 16'd0;
  logic [31:0] exp_pkt = 32'd0;
  logic [15:0] exp_drop = 16'd0;
  logic        stalled = 1'b0;
  logic [64:0] held;

  // Beats are judged at the falling edge, where inputs and registered outputs are settled.
  always @(negedge clk) begin
    if (!reset) begin
      if (stalled && bus.m_axis_tvalid) begin
        checks++;
        if ({bus.m_axis_tlast, bus.m_axis_tdata} !== held) begin
          errors++;
          $display("FAIL stall_stable: got %h expected %h", {bus.m_axis_tlast, bus.m_axis_tdata}, held);
        end
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        logic [64:0] e;
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", {bus.m_axis_tlast, bus.m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({bus.m_axis_tlast, bus.m_axis_tdata} !== e) begin
            errors++;
            $display("FAIL beat: got last=%b data=%h expected last=%b data=%h",
                     bus.m_axis_tlast, bus.m_axis_tdata, e[64], e[63:0]);
          end
        end
      end
      stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
      held    = {bus.m_axis_tlast, bus.m_axis_tdata};
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic push_pkt(input int n, input logic [63:0] base);
    exp_q.push_back({1'b0, 16'hA5C3, exp_seq, 16'(n), 16'h0000});
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), base + 64'(i)});
    exp_seq = exp_seq + 16'd1;
    exp_pkt = exp_pkt + 32'd1;
  endtask

  task automatic write_words(input logic [63:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + 64'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || bus.m_axis_tvalid) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL %s_drain: %0d beats still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_pkt(input string name);
    checks++;
    if (pkt_count !== exp_pkt) begin
      errors++;
      $display("FAIL %s_pkt_count: got %0d expected %0d", name, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.m_axis_tvalid, bus.m_axis_tlast} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100", {bus.in_ready, bus.m_axis_tvalid, bus.m_axis_tlast});
    end
    checks++;
    if (bus.m_axis_tdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_tdata: got %h expected 0", bus.m_axis_tdata);
    end
    checks++;
    if (pkt_count !== 32'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: got pkt=%0d drop=%0d expected 0 0", pkt_count, drop_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_burst;
    bus.m_axis_tready = 1'b1;
    push_pkt(64, 64'd0);
    write_words(64'd0, 64);
    wait_drain("burst", 200);
    check_pkt("burst");
  endtask

  task automatic test_timeout;
    int cyc;
    bus.m_axis_tready = 1'b1;
    push_pkt(3, 64'd100);
    write_words(64'd100, 1);
    cyc = 0;
    write_words(64'd101, 2);
    cyc = 2;
    while (!bus.m_axis_tvalid && cyc < TIMEOUT + 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", cyc, TIMEOUT);
    end
    wait_drain("timeout", 50);
    check_pkt("timeout");
  endtask

  task automatic test_backpressure;
    int c = 0;
    bus.m_axis_tready = 1'b0;
    push_pkt(64, 64'd1000);
    write_words(64'd1000, 64);
    while ((exp_q.size() != 0 || bus.m_axis_tvalid) && c < 1000) begin
      bus.m_axis_tready = ~bus.m_axis_tready;
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c >= 1000) begin
      errors++;
      $display("FAIL backpressure_drain: %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    bus.m_axis_tready = 1'b1;
    check_pkt("backpressure");
  endtask

  task automatic test_overflow;
    bus.m_axis_tready = 1'b0;
    for (int p = 0; p < DEPTH / MAX_WORDS; p++)
      push_pkt(MAX_WORDS, 64'd5000 + 64'(p * MAX_WORDS));
    for (int i = 0; i < DEPTH + 5; i++) begin
      if (i == DEPTH - 1 || i == DEPTH) begin
        checks++;
        if (bus.in_ready !== (i < DEPTH)) begin
          errors++;
          $display("FAIL overflow_in_ready_%0d: got %b expected %b", i, bus.in_ready, (i < DEPTH));
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 64'd5000 + 64'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    exp_drop = exp_drop + 16'd5;
    checks++;
    if (drop_count !== exp_drop) begin
      errors++;
      $display("FAIL overflow_drop_count: got %0d expected %0d", drop_count, exp_drop);
    end
    bus.m_axis_tready = 1'b1;
    wait_drain("overflow", 2000);
    check_pkt("overflow");
  endtask

  task automatic test_flush;
    int seen = 0;
    bus.m_axis_tready = 1'b1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (20) begin
      if (bus.m_axis_tvalid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_empty: got %0d valid cycles expected 0", seen);
    end

    push_pkt(10, 64'd7000);
    write_words(64'd7000, 10);
    repeat (2) @(posedge clk);
    #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_drain("flush10", 50);
    check_pkt("flush10");

    push_pkt(64, 64'd8000);
    write_words(64'd8000, 64);
    while (!bus.m_axis_tvalid && seen < 20) begin
      @(posedge clk); #1;
      seen++;
    end
    repeat (3) @(posedge clk);
    #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_drain("flush_payload", 200);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_payload_extra: got tvalid=%b expected 0", bus.m_axis_tvalid);
    end
    check_pkt("flush_payload");
  endtask

  task automatic test_reset_mid;
    int start;
    int c = 0;
    bus.m_axis_tready = 1'b1;
    push_pkt(64, 64'd9000);
    start = beats;
    write_words(64'd9000, 64);
    while (beats < start + 21 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c >= 200) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d beats expected 21", beats - start);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_seq  = 16'd0;
    exp_pkt  = 32'd0;
    exp_drop = 16'd0;
    checks++;
    if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_flags: got %b expected 001", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.in_ready});
    end
    checks++;
    if (pkt_count !== 32'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_counts: got pkt=%0d drop=%0d expected 0 0", pkt_count, drop_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    push_pkt(64, 64'd9500);
    write_words(64'd9500, 64);
    wait_drain("reset_mid_burst", 200);
    check_pkt("reset_mid_burst");
  endtask

  initial begin
    reset             = 1'b1;
    flush_req         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.m_axis_tready = 1'b1;
    test_reset();
    test_burst();
    test_timeout();
    test_backpressure();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
